// File: rtl/ibex_trace_pkg.sv
// Shared types for the RVFI trace capture controller.
// IBEX_TRACE_CTRL_TIMESTAMP_EN adds a 32-bit retirement timestamp as the record MSB field.
package ibex_trace_pkg;

  typedef enum logic [1:0] {
    TRACE_IDLE    = 2'd0,
    TRACE_ARMED   = 2'd1,
    TRACE_CAPTURE = 2'd2,
    TRACE_STOPPED = 2'd3
  } trace_state_e;

  typedef struct packed {
    logic last;
    logic gap;
    logic intr;
    logic trap;
  } trace_flags_t;

`ifdef IBEX_TRACE_CTRL_TIMESTAMP_EN
  typedef struct packed {
    logic [31:0]  ts;
    trace_flags_t flags;
    logic [31:0]  insn;
    logic [31:0]  pc;
  } trace_rec_t;
`else
  typedef struct packed {
    trace_flags_t flags;
    logic [31:0]  insn;
    logic [31:0]  pc;
  } trace_rec_t;
`endif

  localparam int RecW = $bits(trace_rec_t);

endpackage

// File: rtl/ibex_trace_ctrl_if.sv
// Trace sink handshake: record valid/ready with the packed record payload.
// Record width follows IBEX_TRACE_CTRL_TIMESTAMP_EN through the package.
interface ibex_trace_ctrl_if;
  import ibex_trace_pkg::*;

  logic            trace_valid_o;
  logic            trace_ready_i;
  logic [RecW-1:0] trace_data_o;

  modport master (output trace_valid_o, output trace_data_o, input trace_ready_i);
  modport slave  (input trace_valid_o, input trace_data_o, output trace_ready_i);
endinterface

// File: rtl/ibex_trace_fifo.sv
// Synchronous first-word-fall-through FIFO with registered storage.
// Full/empty come from the occupancy count; a push while full succeeds only with a same-cycle pop.
module ibex_trace_fifo #(
  parameter int Width = 68,
  parameter int Depth = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push,
  input  logic                   pop,
  input  logic [Width-1:0]       wdata,
  output logic [Width-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(Depth):0] level
);
  localparam int AW = $clog2(Depth);
  localparam logic [AW:0] FullLvl = Depth[AW:0];

  logic [Width-1:0] r_mem [Depth];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_level;
  logic             w_push;
  logic             w_pop;

  assign empty  = (r_level == '0);
  assign full   = (r_level == FullLvl);
  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);
  assign level  = r_level;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage is data only; occupancy alone decides what is visible.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= wdata;
  end

  assign rdata = empty ? '0 : r_mem[r_rptr];

endmodule

// File: rtl/ibex_trace_ctrl.sv
// RVFI trace capture controller: arm/trigger/capture/stop FSM, record packing, drop accounting.
// IBEX_TRACE_CTRL_TIMESTAMP_EN appends a free-running cycle count to every record.
module ibex_trace_ctrl
  import ibex_trace_pkg::*;
#(
  parameter int Depth = 8,
  parameter int CntW  = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   rvfi_valid,
  input  logic [31:0]            rvfi_pc_rdata,
  input  logic [31:0]            rvfi_insn,
  input  logic                   rvfi_trap,
  input  logic                   rvfi_intr,
  input  logic                   cfg_arm_i,
  input  logic                   cfg_stop_i,
  input  logic                   cfg_trig_en_i,
  input  logic [31:0]            cfg_trig_pc_i,
  input  logic [CntW-1:0]        cfg_count_i,
  ibex_trace_ctrl_if.master      trace_if,
  output logic [1:0]             state_o,
  output logic [CntW-1:0]        drop_cnt_o,
  output logic [$clog2(Depth):0] fifo_level_o
);

  function automatic logic [CntW-1:0] sat_inc(input logic [CntW-1:0] v);
    return (&v) ? v : v + CntW'(1);
  endfunction

  trace_state_e    r_state;
  trace_state_e    w_next;
  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] r_limit;
  logic [CntW-1:0] r_drop;
  logic [31:0]     r_trig_pc;
  logic            r_gap;
  logic            w_arm;
  logic            w_trig_hit;
  logic            w_obs;
  logic            w_limit_hit;
  logic            w_last;
  logic            w_pop;
  logic            w_push;
  logic            w_drop;
  logic            w_full;
  logic            w_empty;
  trace_rec_t      w_rec;
  logic [RecW-1:0] w_rdata;

  assign w_arm       = cfg_arm_i && (r_state == TRACE_IDLE || r_state == TRACE_STOPPED);
  // A stop in ARMED wins over a coincident trigger match, so that retirement is not captured.
  assign w_trig_hit  = (r_state == TRACE_ARMED) && rvfi_valid && !cfg_stop_i &&
                       (rvfi_pc_rdata == r_trig_pc);
  assign w_obs       = rvfi_valid && ((r_state == TRACE_CAPTURE) || w_trig_hit);
  assign w_limit_hit = w_obs && (r_limit != '0) && ((r_cnt + CntW'(1)) == r_limit);
  assign w_last      = w_obs && (w_limit_hit || cfg_stop_i);
  assign w_pop       = !w_empty && trace_if.trace_ready_i;
  assign w_push      = w_obs && (!w_full || w_pop);
  assign w_drop      = w_obs && w_full && !w_pop;

`ifdef IBEX_TRACE_CTRL_TIMESTAMP_EN
  logic [31:0] r_ts;

  always_ff @(posedge clk_i) begin
    if (rst_i) r_ts <= '0;
    else       r_ts <= r_ts + 32'd1;
  end
`endif

  always_comb begin
    w_rec            = '0;
`ifdef IBEX_TRACE_CTRL_TIMESTAMP_EN
    w_rec.ts         = r_ts;
`endif
    w_rec.flags.last = w_last;
    w_rec.flags.gap  = r_gap;
    w_rec.flags.intr = rvfi_intr;
    w_rec.flags.trap = rvfi_trap;
    w_rec.insn       = rvfi_insn;
    w_rec.pc         = rvfi_pc_rdata;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= TRACE_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      TRACE_IDLE, TRACE_STOPPED: begin
        if (cfg_arm_i) w_next = cfg_trig_en_i ? TRACE_ARMED : TRACE_CAPTURE;
      end
      TRACE_ARMED: begin
        if (cfg_stop_i)      w_next = TRACE_STOPPED;
        else if (w_trig_hit) w_next = w_limit_hit ? TRACE_STOPPED : TRACE_CAPTURE;
      end
      TRACE_CAPTURE: begin
        if (cfg_stop_i || w_limit_hit) w_next = TRACE_STOPPED;
      end
      default: w_next = TRACE_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt  <= '0;
      r_drop <= '0;
      r_gap  <= 1'b0;
    end else if (w_arm) begin
      r_cnt  <= '0;
      r_drop <= '0;
      r_gap  <= 1'b0;
    end else begin
      if (w_obs) r_cnt <= r_cnt + CntW'(1);
      if (w_drop) begin
        r_drop <= sat_inc(r_drop);
        r_gap  <= 1'b1;
      end else if (w_push) begin
        r_gap  <= 1'b0;
      end
    end
  end

  // Session configuration is sampled only at arm time.
  always_ff @(posedge clk_i) begin
    if (w_arm) begin
      r_limit   <= cfg_count_i;
      r_trig_pc <= cfg_trig_pc_i;
    end
  end

  ibex_trace_fifo #(
    .Width (RecW),
    .Depth (Depth)
  ) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (w_push),
    .pop   (w_pop),
    .wdata (w_rec),
    .rdata (w_rdata),
    .full  (w_full),
    .empty (w_empty),
    .level (fifo_level_o)
  );

  assign trace_if.trace_valid_o = !w_empty;
  assign trace_if.trace_data_o  = w_rdata;
  assign state_o                = r_state;
  assign drop_cnt_o             = r_drop;

endmodule

// File: doc/ibex_trace_ctrl.md
Name: ibex_trace_ctrl

Overview:
Capture controller for the core's RVFI retirement stream. Sequences trace capture through arm, PC trigger, capture and stop phases. Packs each retired instruction into a record, buffers it in a FIFO and drains it to a trace sink over a valid/ready handshake. Sits beside the tracing top level, driven by the rvfi_* outputs of the core, and configured by a debug/CSR shim.

Parameters:
Depth, 8, FIFO entries; power of two, >= 2
CntW, 16, width of capture-limit and drop counters

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
rvfi_valid  in  1  instruction retired this cycle
rvfi_pc_rdata  in  32  PC of retired instruction
rvfi_insn  in  32  instruction word
rvfi_trap  in  1  retirement trapped
rvfi_intr  in  1  first instruction of a trap handler
cfg_arm_i  in  1  pulse: start a capture session
cfg_stop_i  in  1  pulse: end the session
cfg_trig_en_i  in  1  1 = wait for PC trigger, 0 = capture immediately
cfg_trig_pc_i  in  32  trigger PC
cfg_count_i  in  CntW  retirements to capture; 0 = unlimited
trace_valid_o  out  1  record available
trace_ready_i  in  1  sink accepts record
trace_data_o  out  RecW  record {flags[3:0], insn, pc}; flags = {last, gap, intr, trap}
state_o  out  2  current state (trace_state_e)
drop_cnt_o  out  CntW  records dropped in this session, saturating
fifo_level_o  out  $clog2(Depth)+1  occupancy

Behaviour:
- Reset, synchronous on rst_i, also mid-session: state IDLE, FIFO flushed, trace_valid_o=0, trace_data_o=0, drop_cnt_o=0, fifo_level_o=0, gap flag and capture counter cleared.
- States: IDLE=0, ARMED=1, CAPTURE=2, STOPPED=3.
- Arming: cfg_arm_i in IDLE or STOPPED clears drop_cnt, the capture counter and the gap flag. It samples cfg_count_i and cfg_trig_pc_i. Next state is ARMED if cfg_trig_en_i=1, else CAPTURE. The FIFO is not flushed; it keeps draining. cfg_arm_i in ARMED or CAPTURE is ignored.
- ARMED: when rvfi_valid=1 and rvfi_pc_rdata == sampled trig PC, go to CAPTURE. The matching retirement is itself captured in the same cycle.
- CAPTURE: every rvfi_valid=1 cycle is one observed retirement and increments the capture counter.
  - Push when the FIFO is not full, or when it is full and a pop happens the same cycle (push-through).
  - Otherwise drop the record: drop_cnt increments, saturating at 2^CntW-1, and the sticky gap flag is set.
  - The next pushed record carries gap=1; the gap flag then clears.
- Stop: go to STOPPED when the capture counter reaches a nonzero limit, or on cfg_stop_i.
  - The retirement that reaches the limit, or that coincides with cfg_stop_i, is pushed with last=1 if space allows.
  - If that record is dropped, no last marker is emitted.
  - cfg_stop_i in ARMED goes to STOPPED. cfg_stop_i in IDLE or STOPPED is ignored.
  - cfg_arm_i and cfg_stop_i together: stop wins in ARMED and CAPTURE; arm wins in IDLE and STOPPED.
- Output side: first-word-fall-through behaviour with registered storage.
  - A record pushed in cycle N is presented in cycle N+1 at the earliest.
  - trace_valid_o = FIFO not empty.
  - trace_data_o is held stable while trace_valid_o=1 and trace_ready_i=0.
  - A pop occurs on valid and ready together. The sink cannot stall the core; overflow only drops records.
- Wrap-around: read and write pointers are $clog2(Depth) bits and wrap modulo Depth. Full and empty are derived from fifo_level_o.

Optional Feature:
IBEX_TRACE_CTRL_TIMESTAMP_EN
- Defined: a free-running 32-bit cycle counter, cleared on reset and wrapping, is appended as the MSB field of each record, so RecW = 100. The timestamp is the cycle of retirement.
- Undefined: the counter is absent and RecW = 68.
- Everything else is identical in both builds.

Decomposition:
- ibex_trace_pkg: trace_state_e (2-bit enum); trace_flags_t packed struct {last, gap, intr, trap}; trace_rec_t packed struct; localparam RecW.
- Sub-module ibex_trace_fifo: a sync FIFO with parameters Width and Depth and ports push, pop, full, empty, level, wdata, rdata. It is instantiated once.
- ibex_trace_ctrl holds the FSM, the counters and the record packing.

Test Plan:
1. trig_en=0, count=4, arm, 6 retirements, ready=1 -> state IDLE→CAPTURE→STOPPED; exactly 4 records; last=1 on the 4th only; drop_cnt=0.
2. trig_en=1, trig_pc=0x80, arm, retire PCs 0x70, 0x80, 0x84 -> 2 records (0x80, 0x84); the 0x70 retirement produces no record.
3. Depth=8, ready=0, count=0, 12 retirements, then ready=1 -> 8 records drained, drop_cnt=4, gap=0 on all; 13th retirement pushed with gap=1.
4. FIFO full, pop and retirement in the same cycle -> record pushed (push-through), drop_cnt unchanged, level stays 8.
5. cfg_stop_i coincides with a retirement in CAPTURE -> that record has last=1, state STOPPED next cycle; a re-arm clears drop_cnt while the FIFO still drains.
6. rst_i asserted mid-capture with level=5 -> next cycle trace_valid_o=0, level=0, state IDLE, drop_cnt=0.
